// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serial pattern transmitter.
//   seq_state_e   - FSM state encoding (GAP is only reachable when
//                   SEQ_TX_GAP_EN is defined)
//   PAT_W_DEFAULT - default pattern width
//   SEQ_1011      - canonical 1011 frame, shared with the detector benches
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

  localparam int PAT_W_DEFAULT = 4;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request/stream bundle for seq_pattern_tx.
//   master modport (requester / downstream side):
//     out   start, pattern[PAT_W], repeat_n[CNT_W], stop, out_ready
//     in    out, out_valid, frame_start, busy, done
//   slave modport (transmitter side): the same signals, directions reversed.
interface seq_pattern_tx_if
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = 8
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             stop;
  logic             out_ready;
  logic             out;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n, stop, out_ready,
    input  out, out_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n, stop, out_ready,
    output out, out_valid, frame_start, busy, done
  );

endinterface

// File: rtl/seq_piso.sv
// seq_piso: PAT_W-bit parallel-load, shift-left register.
//   clk, rst        clock, async active-low reset
//   load_i          load load_val_i (has priority over shift_en_i)
//   load_val_i      parallel value
//   shift_en_i      shift left by one, zero fill
//   msb_o           current MSB
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PAT_W-1:0] load_val_i,
  input  logic             shift_en_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] shreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= load_val_i;
    end else if (shift_en_i) begin
      shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter. Captures a pattern on start
// and shifts it out MSB-first, repeat_n times (0 = until stop), with
// out_ready backpressure.
//   clk, rst   clock, async active-low reset
//   bus        seq_pattern_tx_if.slave (start/pattern/repeat_n/stop/out_ready
//              in; out/out_valid/frame_start/busy/done out)
// Build option: SEQ_TX_GAP_EN inserts a one-cycle GAP state (out_valid=0)
// between consecutive repetitions; undefined gives back-to-back repetitions.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SHIFT | presenting shreg MSB, advancing on out_valid & out_ready
// GAP   | one idle cycle between repetitions (SEQ_TX_GAP_EN only)
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_pattern_tx_if.slave bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             done_q, done_d;
  logic             busy_q, out_valid_q, frame_start_q;
  logic             piso_load, piso_shift, piso_msb;
  logic [PAT_W-1:0] piso_val;
  logic             accept;

  assign accept = out_valid_q & bus.out_ready;

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (piso_load),
    .load_val_i (piso_val),
    .shift_en_i (piso_shift),
    .msb_o      (piso_msb)
  );

  // rep_left stays 0 in continuous mode, so rep_left==1 alone marks the final
  // repetition of a finite run.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    pat_d      = pat_q;
    done_d     = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_val   = pat_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SHIFT;
          pat_d      = bus.pattern;
          piso_val   = bus.pattern;
          piso_load  = 1'b1;
          rep_left_d = bus.repeat_n;
          bit_idx_d  = '0;
        end
      end
      SHIFT: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (accept) begin
          if (bit_idx_q == LAST_IDX) begin
            if (rep_left_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              if (rep_left_q != '0) begin
                rep_left_d = rep_left_q - CNT_W'(1);
              end
              piso_load = 1'b1;
              bit_idx_d = '0;
`ifdef SEQ_TX_GAP_EN
              state_d   = GAP;
`else
              state_d   = SHIFT;
`endif
            end
          end else begin
            piso_shift = 1'b1;
            bit_idx_d  = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        state_d = bus.stop ? IDLE : SHIFT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      rep_left_q    <= '0;
      pat_q         <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      rep_left_q    <= rep_left_d;
      pat_q         <= pat_d;
      done_q        <= done_d;
      busy_q        <= (state_d != IDLE);
      out_valid_q   <= (state_d == SHIFT);
      frame_start_q <= (state_d == SHIFT) && (bit_idx_d == '0);
    end
  end

  // shreg may hold leftover bits after a stop; gating keeps out at 0 when idle.
  assign bus.out         = out_valid_q & piso_msb;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx (PAT_W=4, CNT_W=8).
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8)) bus ();

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] hist;
  int det_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, "_out"},   32'(bus.out),         32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, "_fs"},    32'(bus.frame_start), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),        32'd0);
    check({tag, "_done"},  32'(bus.done),        32'(exp_done));
  endtask

  // Checks n presented bits (MSB of bits[n-1:0] first) with out_ready=1;
  // frame_start expected on every 4th bit. Also feeds a 1011 detector model.
  task automatic run_bits(input string tag, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_out%0d", tag, i),   32'(bus.out),         32'(bits[n-1-i]));
      check($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid),   32'd1);
      check($sformatf("%s_fs%0d", tag, i),    32'(bus.frame_start), 32'((i % 4) == 0));
      check($sformatf("%s_busy%0d", tag, i),  32'(bus.busy),        32'd1);
      check($sformatf("%s_done%0d", tag, i),  32'(bus.done),        32'd0);
      if (bus.out_valid && bus.out_ready) begin
        hist = {hist[2:0], bus.out};
        if (hist == SEQ_1011) det_cnt++;
      end
      tick();
    end
  endtask

  task automatic kick(input logic [3:0] p, input logic [7:0] r);
    bus.pattern  = p;
    bus.repeat_n = r;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.pattern  = ~p;
    bus.repeat_n = r + 8'd5;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pattern   = '0;
    bus.repeat_n  = '0;
    bus.stop      = 1'b0;
    bus.out_ready = 1'b1;
    hist          = '0;
    det_cnt       = 0;

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset", 1'b0);
    rst = 1'b1;
    tick();

    // single run
    kick(SEQ_1011, 8'd1);
    run_bits("single", 16'h000B, 4);
    check_quiet("single_end", 1'b1);
    tick();
    check("single_done_clr", 32'(bus.done), 32'd0);

`ifndef SEQ_TX_GAP_EN
    // three back-to-back repeats, detector loopback
    hist = '0;
    det_cnt = 0;
    kick(SEQ_1011, 8'd3);
    run_bits("rep3", 16'h0BBB, 12);
    check_quiet("rep3_end", 1'b1);
    check("rep3_det", 32'(det_cnt), 32'd3);
    tick();
    check("rep3_done_clr", 32'(bus.done), 32'd0);
`endif

    // backpressure on bit 1 for 3 cycles
    kick(SEQ_1011, 8'd1);
    check("bp_b0", 32'(bus.out), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_hold_out%0d", k),   32'(bus.out),         32'd0);
      check($sformatf("bp_hold_valid%0d", k), 32'(bus.out_valid),   32'd1);
      check($sformatf("bp_hold_fs%0d", k),    32'(bus.frame_start), 32'd0);
      bus.out_ready = (k == 3);
      tick();
    end
    check("bp_b2", 32'(bus.out), 32'd1);
    tick();
    check("bp_b3", 32'(bus.out), 32'd1);
    check("bp_b3_done", 32'(bus.done), 32'd0);
    tick();
    check_quiet("bp_end", 1'b1);
    tick();

`ifndef SEQ_TX_GAP_EN
    // continuous run, stop on 6th bit; start with it is ignored
    kick(SEQ_1011, 8'd0);
    run_bits("cont", 16'h0017, 5);
    check("stop_b5", 32'(bus.out), 32'd0);
    bus.stop    = 1'b1;
    bus.start   = 1'b1;
    bus.pattern = 4'b0110;
    bus.repeat_n = 8'd1;
    tick();
    check_quiet("stop_idle", 1'b0);
    bus.stop = 1'b0;
    tick();
    bus.start = 1'b0;
    run_bits("restart", 16'h0006, 4);
    check_quiet("restart_end", 1'b1);
    tick();
`endif

    // reset mid-run
    kick(SEQ_1011, 8'd0);
    run_bits("prerst", 16'h0002, 2);
    rst = 1'b0;
    #1;
    check_quiet("midrst", 1'b0);
    tick();
    rst = 1'b1;
    tick();
    kick(4'b1100, 8'd1);
    run_bits("postrst", 16'h000C, 4);
    check_quiet("postrst_end", 1'b1);
    tick();

`ifdef SEQ_TX_GAP_EN
    // gap between two repeats
    kick(SEQ_1011, 8'd2);
    run_bits("gap_a", 16'h000B, 4);
    check("gap_valid", 32'(bus.out_valid), 32'd0);
    check("gap_out",   32'(bus.out),       32'd0);
    check("gap_busy",  32'(bus.busy),      32'd1);
    check("gap_done",  32'(bus.done),      32'd0);
    tick();
    run_bits("gap_b", 16'h000B, 4);
    check_quiet("gap_end", 1'b1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
